edge_event_arbiter: RTL and testbench

- Multi-channel event front-end for asynchronous level inputs such as buttons and external triggers, clocked at 100 MHz (10 ns period).
- Per channel: synchronises the input, detects rising edges, and applies a retrigger holdoff.
- Latches pending events and serialises them to a single downstream consumer over a valid/ready handshake.
- Channel selection is round-robin, so no channel starves.

---
 rtl/edge_event_if.sv | 25 ++
 rtl/edge_event_arbiter.sv | 169 ++++++++++++++++
 tb/tb_edge_event_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_event_if.sv
// Valid/ready event channel carrying the arbitrated channel index
// and its one-hot form from the event arbiter to a single consumer.
interface edge_event_if #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
);
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic [N_CH-1:0] evt_onehot;

  modport master (
    output evt_valid,
    output evt_ch,
    output evt_onehot,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ch,
    input  evt_onehot,
    output evt_ready
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// Per-channel sync + rising-edge detect + holdoff, pending latch,
// and round-robin serialisation onto a valid/ready event channel.
module edge_event_arbiter #(
  parameter int N_CH           = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int CH_W           = $clog2(N_CH),
  parameter int CNT_W          = $clog2(HOLDOFF_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   logic_in,
  input  logic              enable,
  edge_event_if.master      evt,
  output logic [N_CH-1:0]   overflow,
  input  logic              clear_overflow
);

  // Zero holdoff still needs a 1-bit counter that simply stays at 0.
  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CW-1:0] HOLD = CW'(HOLDOFF_CYCLES);
  localparam logic [CH_W:0] NCH  = (CH_W+1)'(N_CH);

  typedef enum logic {IDLE, OFFER} state_e;

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] prev_q;
  logic [N_CH-1:0] edge_q;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [N_CH-1:0] acc;
  logic [N_CH-1:0] hs_mask;
  logic [N_CH-1:0] sel_oh;
  logic [N_CH-1:0] oh_q, oh_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [CH_W-1:0] sel_ch;
  logic [CH_W:0]   idx;
  logic            found;
  logic            hs;
  logic            any_pend;
  state_e          st_q, st_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= logic_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < N_CH; i++) begin
      acc[i] = edge_q[i] & enable & (cnt_q[i] == '0);
      if (acc[i]) begin
        cnt_d[i] = HOLD;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign hs       = (st_q == OFFER) & evt.evt_ready;
  assign hs_mask  = hs ? oh_q : '0;
  assign any_pend = |pend_q;

  // A new edge landing on the channel being handshaken re-arms it
  // rather than counting as an overflow.
  assign pend_d = (pend_q & ~hs_mask) | acc;
  assign ovf_d  = (clear_overflow ? '0 : ovf_q)
                | (acc & pend_q & ~hs_mask);

  always_comb begin
    sel_ch = '0;
    sel_oh = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = {1'b0, ptr_q} + (CH_W+1)'(k);
      if (idx >= NCH) begin
        idx = idx - NCH;
      end
      if (!found && pend_q[idx[CH_W-1:0]]) begin
        found                 = 1'b1;
        sel_ch                = idx[CH_W-1:0];
        sel_oh[idx[CH_W-1:0]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:  if (any_pend) st_d = OFFER;
      OFFER: if (hs)       st_d = IDLE;
    endcase
  end

  always_comb begin
    ch_d  = ch_q;
    oh_d  = oh_q;
    ptr_d = ptr_q;
    unique case (1'b1)
      (st_q == IDLE): begin
        if (any_pend) begin
          ch_d = sel_ch;
          oh_d = sel_oh;
        end
      end
      (st_q == OFFER): begin
        if (hs) begin
          oh_d  = '0;
          ptr_d = (ch_q == CH_W'(N_CH-1)) ? '0
                : ch_q + CH_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovf_q  <= '0;
      oh_q   <= '0;
      ch_q   <= '0;
      ptr_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      oh_q   <= oh_d;
      ch_q   <= ch_d;
      ptr_q  <= ptr_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign evt.evt_valid  = (st_q == OFFER);
  assign evt.evt_ch     = ch_q;
  assign evt.evt_onehot = oh_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed + random bench for edge_event_arbiter against a
// cycle-stepped behavioural model of the event rules.
module tb_edge_event_arbiter;
  localparam int N = 4;
  localparam int H = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] li = '0;
  logic       en = 1'b1;
  logic       clr = 1'b0;
  logic       rdy = 1'b0;
  logic [3:0] ovf;

  edge_event_if #(.N_CH(N)) eif ();
  assign eif.evt_ready = rdy;

  always #5 clk = ~clk;

  edge_event_arbiter #(
    .N_CH(N), .SYNC_STAGES(2), .HOLDOFF_CYCLES(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .logic_in(li), .enable(en),
    .evt(eif.master), .overflow(ovf), .clear_overflow(clr)
  );

  int checks = 0;
  int failures = 0;

  logic [3:0] hist[$];
  int         last_acc[N];
  logic [3:0] m_pend, m_ovf;
  int         m_ptr, m_ch;
  bit         m_off;
  int         got[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    hist.delete();
    repeat (4) hist.push_back(4'h0);
    for (int i = 0; i < N; i++) last_acc[i] = -1000;
    m_pend = '0;
    m_ovf  = '0;
    m_ptr  = 0;
    m_ch   = 0;
    m_off  = 1'b0;
  endtask

  // Input sampled at clock t-3 with a low sample at t-4 is the
  // rising edge presented for acceptance at clock t.
  task automatic model_step();
    int t;
    logic [3:0] acc, hsm, old;
    bit hs;
    t   = hist.size() - 1;
    acc = '0;
    hsm = '0;
    for (int i = 0; i < N; i++) begin
      if (hist[t-3][i] && !hist[t-4][i] && en &&
          (t - last_acc[i] > H)) begin
        acc[i] = 1'b1;
        last_acc[i] = t;
      end
    end
    hs = m_off && rdy;
    if (hs) hsm[m_ch] = 1'b1;
    old    = m_pend;
    m_ovf  = (clr ? 4'h0 : m_ovf) | (acc & old & ~hsm);
    m_pend = (old & ~hsm) | acc;
    if (hs) begin
      m_off = 1'b0;
      m_ptr = (m_ch + 1) % N;
    end else if (!m_off && old != 0) begin
      for (int k = 0; k < N; k++) begin
        if (!m_off && old[(m_ptr + k) % N]) begin
          m_off = 1'b1;
          m_ch  = (m_ptr + k) % N;
        end
      end
    end
  endtask

  task automatic tick();
    bit dut_hs;
    int dut_ch;
    dut_hs = eif.evt_valid && rdy;
    dut_ch = int'(eif.evt_ch);
    @(posedge clk);
    hist.push_back(li);
    model_step();
    if (dut_hs) got.push_back(dut_ch);
    @(negedge clk);
    chk("valid", 32'(eif.evt_valid), 32'(m_off));
    if (m_off) chk("ch", 32'(eif.evt_ch), 32'(m_ch));
    chk("onehot", 32'(eif.evt_onehot),
        m_off ? (32'd1 << m_ch) : 32'd0);
    chk("overflow", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic chk_order(string tag, int e0, int e1, int e2, int e3);
    int exp[4];
    exp = '{e0, e1, e2, e3};
    chk({tag, "_n"}, 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(eif.evt_valid), 0);
    chk("rst_ch", 32'(eif.evt_ch), 0);
    chk("rst_onehot", 32'(eif.evt_onehot), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    m_reset();

    rdy = 1'b1;
    got.delete();
    li = 4'hF;
    repeat (16) tick();
    chk_order("rr_p0", 0, 1, 2, 3);
    li = 4'h0;
    repeat (25) tick();
    li = 4'h2;
    repeat (10) tick();
    li = 4'h0;
    repeat (25) tick();
    got.delete();
    li = 4'hF;
    repeat (16) tick();
    chk_order("rr_p2", 2, 3, 0, 1);
    li = 4'h0;
    repeat (25) tick();

    li = 4'h4;
    repeat (4) tick();
    chk("lat_early", 32'(eif.evt_valid), 0);
    tick();
    chk("lat_valid", 32'(eif.evt_valid), 1);
    chk("lat_ch", 32'(eif.evt_ch), 2);
    chk("lat_onehot", 32'(eif.evt_onehot), 32'h4);
    tick();
    chk("one_wide", 32'(eif.evt_valid), 0);
    li = 4'h0;
    repeat (25) tick();

    rdy = 1'b0;
    li  = 4'h2;
    repeat (5) tick();
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("bp_valid", 32'(eif.evt_valid), 1);
      chk("bp_ch", 32'(eif.evt_ch), 1);
      chk("bp_onehot", 32'(eif.evt_onehot), 32'h2);
    end
    got.delete();
    rdy = 1'b1;
    repeat (10) tick();
    chk("bp_count", 32'(got.size()), 1);
    li = 4'h0;
    repeat (25) tick();

    got.delete();
    for (int c = 0; c < 240; c++) begin
      li[3] = ((c / 10) % 2) == 1;
      tick();
    end
    chk("holdoff_count", 32'(got.size()), 6);
    chk("holdoff_ovf", 32'(ovf[3]), 0);
    li = 4'h0;
    repeat (25) tick();

    rdy = 1'b0;
    li  = 4'h1;
    repeat (3) tick();
    li  = 4'h0;
    repeat (25) tick();
    li  = 4'h1;
    repeat (6) tick();
    chk("ovf_set", 32'(ovf[0]), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_clear", 32'(ovf), 0);
    li = 4'h0;
    repeat (25) tick();
    li = 4'h1;
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_set_wins", 32'(ovf[0]), 1);
    got.delete();
    rdy = 1'b1;
    repeat (6) tick();
    chk("ovf_single_n", 32'(got.size()), 1);
    if (got.size() > 0) chk("ovf_single_ch", 32'(got[0]), 0);
    li  = 4'h0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (25) tick();

    rdy = 1'b0;
    li  = 4'h4;
    repeat (6) tick();
    chk("ar_pre_valid", 32'(eif.evt_valid), 1);
    rdy = 1'b1;
    #2;
    rst_n = 1'b0;
    li    = 4'h0;
    #1;
    chk("ar_valid", 32'(eif.evt_valid), 0);
    chk("ar_onehot", 32'(eif.evt_onehot), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    got.delete();
    repeat (12) tick();
    chk("ar_quiet", 32'(got.size()), 0);
    li = 4'h8;
    repeat (6) tick();
    chk("ar_new_n", 32'(got.size()), 1);
    li = 4'h0;
    repeat (25) tick();

    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      en  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) li[i] = ~li[i];
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
